// File: rtl/pe_ws_double_buffered.sv
// Weight-stationary PE with a double-buffered weight: a shadow register fills over the column chain
// while the active weight computes. Optional saturating sum under `define PE_WS_SATURATE_EN.
module pe_ws_double_buffered #(
  parameter int WORDWIDTH = 8,
  parameter int PSWIDTH   = 32,
  parameter int PIPE      = 1,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 w_valid_in,
  input  logic [WORDWIDTH-1:0] w_in,
  input  logic                 w_capture_in,
  input  logic                 swap_in,
  input  logic                 enable_in,
  input  logic [WORDWIDTH-1:0] a_in,
  input  logic [PSWIDTH-1:0]   ps_in,
  output logic                 w_valid_out,
  output logic [WORDWIDTH-1:0] w_out,
  output logic                 w_capture_out,
  output logic                 swap_out,
  output logic                 enable_out,
  output logic [WORDWIDTH-1:0] a_out,
  output logic                 ps_valid_out,
  output logic [PSWIDTH-1:0]   ps_out,
  output logic                 w_ready,
  output logic                 swap_err
`ifdef PE_WS_SATURATE_EN
  ,
  output logic                 sat_flag
`endif
);

  generate
    if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
      $error("pe_ws_double_buffered: PIPE must be 1 or 2");
    end
    if (PSWIDTH < 2 * WORDWIDTH) begin : g_bad_pswidth
      $error("pe_ws_double_buffered: PSWIDTH must be >= 2*WORDWIDTH");
    end
  endgenerate

  logic [WORDWIDTH-1:0] shadow;
  logic [WORDWIDTH-1:0] active;
  logic                 shadow_full;
  logic                 capture;

  assign capture = w_valid_in & w_capture_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_valid_out   <= 1'b0;
      w_out         <= '0;
      w_capture_out <= 1'b0;
      swap_out      <= 1'b0;
      enable_out    <= 1'b0;
      a_out         <= '0;
      shadow        <= '0;
      active        <= '0;
      shadow_full   <= 1'b0;
      w_ready       <= 1'b0;
      swap_err      <= 1'b0;
    end else begin
      w_valid_out   <= w_valid_in;
      w_out         <= w_in;
      w_capture_out <= w_capture_in;
      swap_out      <= swap_in;
      enable_out    <= enable_in;
      if (enable_in) a_out <= a_in;
      if (capture) shadow <= w_in;
      // A capture coinciding with a swap refills the shadow the swap just drained.
      shadow_full <= capture | (shadow_full & ~swap_in);
      if (swap_in) begin
        if (shadow_full) begin
          active  <= shadow;
          w_ready <= 1'b1;
        end else begin
          swap_err <= 1'b1;
        end
      end
    end
  end

  // Operands are widened to PSWIDTH so the product is exact and already extended.
  logic signed [PSWIDTH-1:0] a_ext;
  logic signed [PSWIDTH-1:0] w_ext;
  logic        [PSWIDTH-1:0] prod;

  always_comb begin
    if (SIGNED != 0) begin
      a_ext = PSWIDTH'($signed(a_in));
      w_ext = PSWIDTH'($signed(active));
    end else begin
      a_ext = PSWIDTH'(a_in);
      w_ext = PSWIDTH'(active);
    end
    prod = a_ext * w_ext;
  end

  logic               mac_valid;
  logic [PSWIDTH-1:0] mac_prod;
  logic [PSWIDTH-1:0] mac_ps;

  generate
    if (PIPE == 2) begin : g_pipe2
      logic               s1_valid;
      logic [PSWIDTH-1:0] s1_prod;
      logic [PSWIDTH-1:0] s1_ps;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_valid <= 1'b0;
          s1_prod  <= '0;
          s1_ps    <= '0;
        end else begin
          s1_valid <= enable_in;
          if (enable_in) begin
            s1_prod <= prod;
            s1_ps   <= ps_in;
          end
        end
      end

      assign mac_valid = s1_valid;
      assign mac_prod  = s1_prod;
      assign mac_ps    = s1_ps;
    end else begin : g_pipe1
      assign mac_valid = enable_in;
      assign mac_prod  = prod;
      assign mac_ps    = ps_in;
    end
  endgenerate

  logic [PSWIDTH-1:0] sum_res;

`ifdef PE_WS_SATURATE_EN
  logic [PSWIDTH:0] sum_full;
  logic             clip;

  always_comb begin
    sum_full = {((SIGNED != 0) ? mac_ps[PSWIDTH-1] : 1'b0), mac_ps}
             + {((SIGNED != 0) ? mac_prod[PSWIDTH-1] : 1'b0), mac_prod};
    sum_res  = sum_full[PSWIDTH-1:0];
    clip     = 1'b0;
    if (SIGNED != 0) begin
      if (sum_full[PSWIDTH] != sum_full[PSWIDTH-1]) begin
        clip    = 1'b1;
        sum_res = sum_full[PSWIDTH] ? {1'b1, {(PSWIDTH-1){1'b0}}} : {1'b0, {(PSWIDTH-1){1'b1}}};
      end
    end else if (sum_full[PSWIDTH]) begin
      clip    = 1'b1;
      sum_res = '1;
    end
  end
`else
  assign sum_res = mac_ps + mac_prod;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_valid_out <= 1'b0;
      ps_out       <= '0;
`ifdef PE_WS_SATURATE_EN
      sat_flag     <= 1'b0;
`endif
    end else begin
      ps_valid_out <= mac_valid;
      if (mac_valid) ps_out <= sum_res;
`ifdef PE_WS_SATURATE_EN
      sat_flag     <= mac_valid & clip;
`endif
    end
  end

endmodule

// File: tb/tb_pe_ws_double_buffered.sv
// Scoreboard bench for pe_ws_double_buffered: two instances (PIPE=1 unsigned 32-bit, PIPE=2 signed 16-bit)
// share stimulus; a behavioural model predicts results that a separate monitor pops and compares.
module tb_pe_ws_double_buffered;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        w_valid_in = 1'b0;
  logic [7:0]  w_in = '0;
  logic        w_capture_in = 1'b0;
  logic        swap_in = 1'b0;
  logic        enable_in = 1'b0;
  logic [7:0]  a_in = '0;
  logic [31:0] ps_in = '0;

  logic        wvo_a, wco_a, swo_a, eno_a, psv_a, rdy_a, err_a;
  logic [7:0]  wo_a, ao_a;
  logic [31:0] pso_a;
  logic        wvo_b, wco_b, swo_b, eno_b, psv_b, rdy_b, err_b;
  logic [7:0]  wo_b, ao_b;
  logic [15:0] pso_b;
`ifdef PE_WS_SATURATE_EN
  logic        sat_a, sat_b;
`endif

  always #5 clk = ~clk;

  pe_ws_double_buffered #(.WORDWIDTH(8), .PSWIDTH(32), .PIPE(1), .SIGNED(0)) u_a (
    .clk(clk), .reset_n(reset_n), .w_valid_in(w_valid_in), .w_in(w_in),
    .w_capture_in(w_capture_in), .swap_in(swap_in), .enable_in(enable_in),
    .a_in(a_in), .ps_in(ps_in), .w_valid_out(wvo_a), .w_out(wo_a),
    .w_capture_out(wco_a), .swap_out(swo_a), .enable_out(eno_a), .a_out(ao_a),
    .ps_valid_out(psv_a), .ps_out(pso_a), .w_ready(rdy_a), .swap_err(err_a)
`ifdef PE_WS_SATURATE_EN
    , .sat_flag(sat_a)
`endif
  );

  pe_ws_double_buffered #(.WORDWIDTH(8), .PSWIDTH(16), .PIPE(2), .SIGNED(1)) u_b (
    .clk(clk), .reset_n(reset_n), .w_valid_in(w_valid_in), .w_in(w_in),
    .w_capture_in(w_capture_in), .swap_in(swap_in), .enable_in(enable_in),
    .a_in(a_in), .ps_in(ps_in[15:0]), .w_valid_out(wvo_b), .w_out(wo_b),
    .w_capture_out(wco_b), .swap_out(swo_b), .enable_out(eno_b), .a_out(ao_b),
    .ps_valid_out(psv_b), .ps_out(pso_b), .w_ready(rdy_b), .swap_err(err_b)
`ifdef PE_WS_SATURATE_EN
    , .sat_flag(sat_b)
`endif
  );

  typedef struct {
    logic [31:0] ps;
    bit          clip;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: what the PE should hold after the most recent driven cycle.
  logic [7:0]  m_shadow, m_active, m_aout;
  bit          m_full, m_ready, m_err;
  logic        e_wv, e_cap, e_swp, e_en;
  logic [7:0]  e_w;
  logic [31:0] last_a;
  logic [31:0] last_b;

  function automatic exp_t mac_model(logic [31:0] ps, logic [7:0] a, logic [7:0] w, bit sgn, int psw);
    exp_t   r;
    longint mask, pv, av, wv, s, hi, lo;
    mask = (longint'(1) << psw) - 1;
    pv = longint'(ps) & mask;
    if (sgn && pv >= (longint'(1) << (psw - 1))) pv = pv - (longint'(1) << psw);
    av = sgn ? longint'($signed(a)) : longint'(a);
    wv = sgn ? longint'($signed(w)) : longint'(w);
    s = pv + av * wv;
    r.clip = 1'b0;
    hi = sgn ? (longint'(1) << (psw - 1)) - 1 : mask;
    lo = sgn ? -(longint'(1) << (psw - 1)) : 0;
`ifdef PE_WS_SATURATE_EN
    if (s > hi) begin
      s = hi;
      r.clip = 1'b1;
    end else if (s < lo) begin
      s = lo;
      r.clip = 1'b1;
    end
`else
    if (hi < lo) r.clip = 1'b1;
`endif
    r.ps = 32'(s & mask);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_shadow = '0; m_active = '0; m_aout = '0;
    m_full = 0; m_ready = 0; m_err = 0;
    e_wv = 0; e_cap = 0; e_swp = 0; e_en = 0; e_w = '0;
    last_a = '0; last_b = '0;
    qa.delete();
    qb.delete();
  endtask

  task automatic drive(input bit wv, input bit cap, input bit swp, input bit en,
                       input logic [7:0] w, input logic [7:0] a, input logic [31:0] ps);
    bit c;
    @(negedge clk);
    w_valid_in = wv; w_capture_in = cap; swap_in = swp; enable_in = en;
    w_in = w; a_in = a; ps_in = ps;
    if (en) begin
      qa.push_back(mac_model(ps, a, m_active, 1'b0, 32));
      qb.push_back(mac_model(ps, a, m_active, 1'b1, 16));
      m_aout = a;
    end
    c = wv && cap;
    if (swp) begin
      if (m_full) begin
        m_active = m_shadow;
        m_ready = 1;
        m_full = 0;
      end else begin
        m_err = 1;
      end
    end
    if (c) begin
      m_shadow = w;
      m_full = 1;
    end
    e_wv = wv; e_cap = cap; e_swp = swp; e_en = en; e_w = w;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    w_valid_in = 0; w_capture_in = 0; swap_in = 0; enable_in = 0;
    w_in = '0; a_in = '0; ps_in = '0;
    model_clear();
    #1;
    chk("reset_outputs_a", {wvo_a, wo_a, wco_a, swo_a, eno_a, ao_a, psv_a, pso_a, rdy_a, err_a}, 64'd0);
    chk("reset_outputs_b", {wvo_b, wo_b, wco_b, swo_b, eno_b, ao_b, psv_b, pso_b, rdy_b, err_b}, 64'd0);
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: compares one cycle's outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        chk("ctrl_a", {wvo_a, wo_a, wco_a, swo_a, eno_a, ao_a, rdy_a, err_a},
            {e_wv, e_w, e_cap, e_swp, e_en, m_aout, m_ready, m_err});
        chk("ctrl_b", {wvo_b, wo_b, wco_b, swo_b, eno_b, ao_b, rdy_b, err_b},
            {e_wv, e_w, e_cap, e_swp, e_en, m_aout, m_ready, m_err});
        if (psv_a) begin
          if (qa.size() == 0) begin
            chk("ps_valid_a_unexpected", 64'(psv_a), 64'd0);
          end else begin
            e = qa.pop_front();
            chk("ps_out_a", 64'(pso_a), 64'(e.ps));
            last_a = e.ps;
`ifdef PE_WS_SATURATE_EN
            chk("sat_flag_a", 64'(sat_a), 64'(e.clip));
`endif
          end
        end else begin
          chk("ps_hold_a", 64'(pso_a), 64'(last_a));
`ifdef PE_WS_SATURATE_EN
          chk("sat_idle_a", 64'(sat_a), 64'd0);
`endif
        end
        if (psv_b) begin
          if (qb.size() == 0) begin
            chk("ps_valid_b_unexpected", 64'(psv_b), 64'd0);
          end else begin
            e = qb.pop_front();
            chk("ps_out_b", 64'(pso_b), 64'(e.ps));
            last_b = e.ps;
`ifdef PE_WS_SATURATE_EN
            chk("sat_flag_b", 64'(sat_b), 64'(e.clip));
`endif
          end
        end else begin
          chk("ps_hold_b", 64'(pso_b), 64'(last_b));
`ifdef PE_WS_SATURATE_EN
          chk("sat_idle_b", 64'(sat_b), 64'd0);
`endif
        end
      end
    end
  end

  initial begin
    logic [31:0] ps;
    model_clear();
    do_reset(3);

    // Empty-shadow swap, then a MAC with no weight loaded.
    drive(0, 0, 1, 0, 8'd0, 8'd0, 32'd0);
    drive(0, 0, 0, 1, 8'd0, 8'd9, 32'd7);
    // Basic MAC: w=3, a=2, ps=5.
    drive(1, 1, 0, 0, 8'd3, 8'd0, 32'd0);
    drive(0, 0, 1, 0, 8'd0, 8'd0, 32'd0);
    drive(0, 0, 0, 1, 8'd0, 8'd2, 32'd5);
    // Double buffering: stream with active=3 while 7 loads, swap on the a=4 beat.
    drive(1, 1, 0, 1, 8'd7, 8'd1, 32'd0);
    drive(0, 0, 0, 1, 8'd0, 8'd2, 32'd0);
    drive(0, 0, 0, 1, 8'd0, 8'd3, 32'd0);
    drive(0, 0, 1, 1, 8'd0, 8'd4, 32'd0);
    drive(0, 0, 0, 1, 8'd0, 8'd4, 32'd0);
    // Swap and capture together.
    drive(1, 1, 1, 1, 8'd5, 8'd6, 32'd1);
    drive(0, 0, 0, 1, 8'd0, 8'd6, 32'd1);
    // w=0xFC, a=5, ps=100 (signed -> 80, unsigned -> 1360).
    drive(1, 1, 1, 0, 8'hFC, 8'd0, 32'd0);
    drive(0, 0, 1, 0, 8'd0, 8'd0, 32'd0);
    drive(0, 0, 0, 1, 8'd0, 8'd5, 32'd100);
    // Boundary of the 16-bit signed sum: 32767 + 1*1.
    drive(1, 1, 0, 0, 8'd1, 8'd0, 32'd0);
    drive(0, 0, 1, 0, 8'd0, 8'd0, 32'd0);
    drive(0, 0, 0, 1, 8'd0, 8'd1, 32'd32767);
    drive(0, 0, 0, 1, 8'd0, 8'd1, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 8'd0, 8'd0, 32'd0);
    drive(0, 0, 0, 0, 8'd0, 8'd0, 32'd0);
    // Reset with a beat in flight in the 2-stage instance.
    drive(1, 1, 1, 0, 8'd3, 8'd0, 32'd0);
    drive(0, 0, 1, 0, 8'd0, 8'd0, 32'd0);
    drive(0, 0, 0, 1, 8'd0, 8'd2, 32'd0);
    do_reset(2);
    repeat (4) drive(0, 0, 0, 0, 8'd0, 8'd0, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      ps = $urandom;
      if ($urandom_range(0, 7) == 0) ps = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : 32'h0000_7FF0;
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), ps);
      if (i == 1000) do_reset(2);
    end
    repeat (5) drive(0, 0, 0, 0, 8'd0, 8'd0, 32'd0);
    @(negedge clk);
    chk("pending_results_a", 64'(qa.size()), 64'd0);
    chk("pending_results_b", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
